bus_arbiter_n: RTL and testbench
================================

BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

Interface
REQ-001 Parameter N, default 2: number of requester channels, legal range 2..8.
REQ-002 Parameter DATA_W, default 64: bus data width.
REQ-003 Parameter TAG_W, default 13: bus tag width.
REQ-004 Parameter BEATS, default 8: number of read-response beats, and number of write-data beats, per transaction.
REQ-005 Parameter WR_BIT, default 12: tag bit that marks a write transaction.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  reset; synchronous, active-high.
REQ-008 ch_reqcyc  in  N  per-channel request valid.
REQ-009 ch_req  in  N*DATA_W  per-channel address, then write data; channel i occupies slice [i*DATA_W +: DATA_W].
REQ-010 ch_reqtag  in  N*TAG_W  per-channel tag.
REQ-011 ch_reqack  out  N  per-channel accept of the address beat and each write-data beat.
REQ-012 ch_respcyc  out  N  per-channel response valid.
REQ-013 ch_resp  out  DATA_W  response data, broadcast to all channels.
REQ-014 ch_resptag  out  TAG_W  response tag, broadcast to all channels.
REQ-015 ch_respack  in  N  per-channel response-beat acknowledge.
REQ-016 bus_reqcyc, bus_req, bus_reqtag  out  1/DATA_W/TAG_W  system bus request side.
REQ-017 bus_reqack  in  1  system bus accept.
REQ-018 bus_respcyc, bus_resp, bus_resptag  in  1/DATA_W/TAG_W  system bus response side.
REQ-019 bus_respack  out  1  system bus response acknowledge.
REQ-020 grant  out  log2(N), minimum 1  owning channel; for debug and for the bench.

Function
REQ-021 The FSM SHALL have the states IDLE, ADDR, WDATA and RESP; exactly one transaction SHALL be outstanding at a time.
REQ-022 IDLE: the block SHALL pick the first channel with reqcyc=1 at or after rr_ptr, modulo N, register it as grant, and enter ADDR on the next cycle; if no channel has reqcyc=1, it SHALL stay in IDLE.
REQ-023 ADDR: bus_reqcyc/bus_req/bus_reqtag SHALL mirror the granted channel combinationally, and ch_reqack[grant] SHALL equal bus_reqack.
REQ-024 ADDR exit: when bus_reqack=1 and tag[WR_BIT]=1, the FSM SHALL go to WDATA; when bus_reqack=1 and tag[WR_BIT]=0, it SHALL go to RESP.
REQ-025 WDATA: the block SHALL forward BEATS beats using the same mirroring as ADDR, counting each beat with bus_reqack=1; after the final beat it SHALL go to IDLE with no response phase.
REQ-026 RESP: ch_respcyc[grant] SHALL equal bus_respcyc; resp and resptag SHALL pass through unmodified; bus_respack SHALL equal ch_respack[grant].
REQ-027 RESP counting: a beat SHALL be counted only when bus_respcyc=1 and ch_respack[grant]=1; after BEATS counted beats the FSM SHALL go to IDLE.
REQ-028 Completion: on return to IDLE from WDATA or RESP, rr_ptr SHALL become (grant+1) mod N.
REQ-029 Non-granted channels SHALL see reqack=0 and respcyc=0 at all times.
REQ-030 Any bus response arriving in IDLE, ADDR or WDATA SHALL be dropped, with bus_respack=0.
REQ-031 If the granted channel drops reqcyc while in ADDR, the request SHALL be abandoned and the FSM SHALL return to IDLE without advancing rr_ptr.
REQ-032 The beat counter SHALL be clog2(BEATS)+1 bits wide and SHALL clear on every entry to WDATA or RESP.
REQ-033 Arbitration latency SHALL be 1 cycle from reqcyc in IDLE to bus_reqcyc.
REQ-034 Back-to-back transactions SHALL incur exactly one IDLE cycle between them.

Reset
REQ-035 When reset=1 at a clock edge, the FSM SHALL go to IDLE, rr_ptr and grant SHALL become 0, and the beat counter SHALL become 0.
REQ-036 While in IDLE, all bus_* and ch_* outputs SHALL be 0.
REQ-037 A reset mid-transaction SHALL abandon the transaction immediately, with no completion beats emitted.

Structure
REQ-038 The arb_state_t enum and the defaults for BEATS and WR_BIT SHALL live in the shared package bus_pkg.
REQ-039 Round-robin selection SHALL be one sub-module, rr_select (N-bit request, pointer -> index plus valid), that is purely combinational.
REQ-040 The existing two-port instruction/data arbiter SHALL be replaceable by this block instantiated with N=2, with instruction fetch on channel 0 and data memory on channel 1.

Verification
REQ-041 N=2, both channels raise reqcyc in the same cycle after reset -> grant=0 first; channel 1 granted one IDLE cycle after channel 0's 8th respack.
REQ-042 Read, tag 0x0040: bus returns 8 beats, with bus_respcyc deasserted for 2 cycles between beat 3 and beat 4 -> ch_respcyc[0] pulses exactly 8 times; the FSM returns to IDLE after beat 8.
REQ-043 Write, tag 0x1040, bus_reqack held low for 3 cycles -> no ch_reqack during the stall, then 1 address beat plus 8 data beats acked, and no RESP state is entered.
REQ-044 N=4, channels 1 and 3 requesting continuously -> grants alternate 1,3,1,3; channels 0 and 2 never granted.
REQ-045 Reset asserted at response beat 5 -> the next cycle is IDLE with all outputs 0; a spurious bus response afterwards gets bus_respack=0.
REQ-046 Channel 0 drops reqcyc in ADDR -> return to IDLE; rr_ptr stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the system-bus arbiter family.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int BEATS_DEFAULT  = 8;
    localparam int WR_BIT_DEFAULT = 12;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo N.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-channel system-bus arbiter: round-robin grant, one transaction outstanding,
// address beat then either BEATS write-data beats or BEATS read-response beats.
module bus_arbiter_n
    import bus_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = BEATS_DEFAULT,
    parameter int WR_BIT = WR_BIT_DEFAULT,
    localparam int GW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        ch_reqcyc,
    input  logic [N*DATA_W-1:0] ch_req,
    input  logic [N*TAG_W-1:0]  ch_reqtag,
    output logic [N-1:0]        ch_reqack,
    output logic [N-1:0]        ch_respcyc,
    output logic [DATA_W-1:0]   ch_resp,
    output logic [TAG_W-1:0]    ch_resptag,
    input  logic [N-1:0]        ch_respack,
    output logic                bus_reqcyc,
    output logic [DATA_W-1:0]   bus_req,
    output logic [TAG_W-1:0]    bus_reqtag,
    input  logic                bus_reqack,
    input  logic                bus_respcyc,
    input  logic [DATA_W-1:0]   bus_resp,
    input  logic [TAG_W-1:0]    bus_resptag,
    output logic                bus_respack,
    output logic [GW-1:0]       grant
);

    localparam int CW = $clog2(BEATS) + 1;

    arb_state_t          state, state_nx;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       next_ptr;
    logic [CW-1:0]       beat_cnt;
    logic [GW-1:0]       sel_idx;
    logic                sel_valid;
    logic [DATA_W-1:0]   g_req;
    logic [TAG_W-1:0]    g_tag;
    logic                wr_beat, rd_beat, last_beat;

    rr_select #(.N(N), .IDX_W(GW)) u_rr_select (
        .req   (ch_reqcyc),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_comb begin
        g_req     = ch_req[int'(grant)*DATA_W +: DATA_W];
        g_tag     = ch_reqtag[int'(grant)*TAG_W +: TAG_W];
        wr_beat   = (state == WDATA) && bus_reqack;
        rd_beat   = (state == RESP) && bus_respcyc && ch_respack[grant];
        last_beat = (beat_cnt == CW'(BEATS - 1));
        next_ptr  = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (sel_valid) state_nx = ADDR;
            ADDR: begin
                // A requester that withdraws before acceptance forfeits its turn silently.
                if (!ch_reqcyc[grant])  state_nx = IDLE;
                else if (bus_reqack)    state_nx = g_tag[WR_BIT] ? WDATA : RESP;
            end
            WDATA: if (wr_beat && last_beat) state_nx = IDLE;
            RESP:  if (rd_beat && last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && sel_valid)
                grant <= sel_idx;
            if ((state == WDATA || state == RESP) && state_nx == IDLE)
                rr_ptr <= next_ptr;
            if (state == ADDR)
                beat_cnt <= '0;
            else if (wr_beat || rd_beat)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        ch_reqack   = '0;
        ch_respcyc  = '0;
        ch_resp     = '0;
        ch_resptag  = '0;
        bus_respack = 1'b0;
        case (state)
            ADDR, WDATA: begin
                bus_reqcyc       = ch_reqcyc[grant];
                bus_req          = g_req;
                bus_reqtag       = g_tag;
                ch_reqack[grant] = bus_reqack;
            end
            RESP: begin
                ch_respcyc[grant] = bus_respcyc;
                ch_resp           = bus_resp;
                ch_resptag        = bus_resptag;
                bus_respack       = ch_respack[grant];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: a 2-channel instance for read/write/abandon/reset
// scenarios and a 4-channel instance for round-robin fairness.
module tb_bus_arbiter_n;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-channel instance
    logic [1:0]   a_reqcyc, a_reqack, a_respcyc, a_respack;
    logic [127:0] a_req;
    logic [25:0]  a_reqtag;
    logic [63:0]  a_resp, a_bus_req, a_bus_resp;
    logic [12:0]  a_resptag, a_bus_reqtag, a_bus_resptag;
    logic         a_bus_reqcyc, a_bus_reqack, a_bus_respcyc, a_bus_respack;
    logic [0:0]   a_grant;

    // Four-channel instance
    logic [3:0]   b_reqcyc, b_reqack, b_respcyc, b_respack;
    logic [255:0] b_req;
    logic [51:0]  b_reqtag;
    logic [63:0]  b_resp, b_bus_req, b_bus_resp;
    logic [12:0]  b_resptag, b_bus_reqtag, b_bus_resptag;
    logic         b_bus_reqcyc, b_bus_reqack, b_bus_respcyc, b_bus_respack;
    logic [1:0]   b_grant;

    bus_arbiter_n #(.N(2)) dut2 (
        .clk(clk), .reset(reset),
        .ch_reqcyc(a_reqcyc), .ch_req(a_req), .ch_reqtag(a_reqtag), .ch_reqack(a_reqack),
        .ch_respcyc(a_respcyc), .ch_resp(a_resp), .ch_resptag(a_resptag), .ch_respack(a_respack),
        .bus_reqcyc(a_bus_reqcyc), .bus_req(a_bus_req), .bus_reqtag(a_bus_reqtag),
        .bus_reqack(a_bus_reqack), .bus_respcyc(a_bus_respcyc), .bus_resp(a_bus_resp),
        .bus_resptag(a_bus_resptag), .bus_respack(a_bus_respack), .grant(a_grant)
    );

    bus_arbiter_n #(.N(4)) dut4 (
        .clk(clk), .reset(reset),
        .ch_reqcyc(b_reqcyc), .ch_req(b_req), .ch_reqtag(b_reqtag), .ch_reqack(b_reqack),
        .ch_respcyc(b_respcyc), .ch_resp(b_resp), .ch_resptag(b_resptag), .ch_respack(b_respack),
        .bus_reqcyc(b_bus_reqcyc), .bus_req(b_bus_req), .bus_reqtag(b_bus_reqtag),
        .bus_reqack(b_bus_reqack), .bus_respcyc(b_bus_respcyc), .bus_resp(b_bus_resp),
        .bus_resptag(b_bus_resptag), .bus_respack(b_bus_respack), .grant(b_grant)
    );

    localparam logic [63:0] ADDR0 = 64'h0000_0000_0000_0400;
    localparam logic [63:0] ADDR1 = 64'h1111_0000_0000_1000;

    // Inputs change just after the falling edge; outputs are sampled 1 ns later,
    // well clear of the rising edge.
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dut2.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut2.state, IDLE); end
        checks++; if (a_grant !== 1'b0 || dut2.rr_ptr !== 1'b0) begin errors++; $display("FAIL reset_ptrs: grant %0d rr_ptr %0d expected 0 0", a_grant, dut2.rr_ptr); end
        checks++; if ({a_bus_reqcyc, a_bus_req, a_bus_reqtag, a_reqack, a_respcyc, a_resp, a_resptag, a_bus_respack} !== '0) begin
            errors++; $display("FAIL reset_outputs: bus_reqcyc %0b reqack %0b respcyc %0b bus_respack %0b expected all 0", a_bus_reqcyc, a_reqack, a_respcyc, a_bus_respack); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arb_read();
        int pulses = 0;
        logic v;
        @(negedge clk);
        a_reqcyc = 2'b11;
        a_req    = {ADDR1, ADDR0};
        a_reqtag = {13'h1040, 13'h0040};
        #1;
        checks++; if (a_bus_reqcyc !== 1'b0) begin errors++; $display("FAIL idle_no_bus_req: got %0b expected 0", a_bus_reqcyc); end
        @(negedge clk); #1;
        checks++; if (dut2.state !== ADDR || a_grant !== 1'b0) begin errors++; $display("FAIL first_grant: state %0d grant %0d expected %0d 0", dut2.state, a_grant, ADDR); end
        checks++; if (a_bus_reqcyc !== 1'b1 || a_bus_req !== ADDR0 || a_bus_reqtag !== 13'h0040) begin
            errors++; $display("FAIL addr_mirror: cyc %0b req %0h tag %0h expected 1 %0h 40", a_bus_reqcyc, a_bus_req, a_bus_reqtag, ADDR0); end
        checks++; if (a_reqack !== 2'b00) begin errors++; $display("FAIL addr_no_ack: got %0b expected 00", a_reqack); end
        a_bus_reqack = 1'b1;
        #1;
        checks++; if (a_reqack !== 2'b01) begin errors++; $display("FAIL addr_ack: got %0b expected 01", a_reqack); end
        @(negedge clk);
        a_bus_reqack = 1'b0;
        a_reqcyc[0]  = 1'b0;
        a_respack    = 2'b11;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            v = (c != 3 && c != 4);
            a_bus_respcyc = v;
            a_bus_resp    = 64'hD000 + 64'(c);
            a_bus_resptag = 13'h0040;
            #1;
            if (a_respcyc[0]) pulses++;
            checks++; if (dut2.state !== RESP || a_respcyc !== {1'b0, v} || a_bus_respack !== 1'b1) begin
                errors++; $display("FAIL resp_cycle%0d: state %0d respcyc %0b respack %0b expected %0d %0b 1", c, dut2.state, a_respcyc, a_bus_respack, RESP, {1'b0, v}); end
            if (v) begin
                checks++; if (a_resp !== 64'hD000 + 64'(c) || a_resptag !== 13'h0040) begin
                    errors++; $display("FAIL resp_data%0d: got %0h/%0h expected %0h/40", c, a_resp, a_resptag, 64'hD000 + 64'(c)); end
            end
        end
        @(negedge clk);
        a_bus_respcyc = 1'b1;
        #1;
        checks++; if (pulses != 8) begin errors++; $display("FAIL resp_pulses: got %0d expected 8", pulses); end
        checks++; if (dut2.state !== IDLE || dut2.rr_ptr !== 1'b1) begin errors++; $display("FAIL read_done: state %0d rr_ptr %0d expected %0d 1", dut2.state, dut2.rr_ptr, IDLE); end
        checks++; if (a_bus_respack !== 1'b0 || a_respcyc !== 2'b00) begin errors++; $display("FAIL idle_drop_resp: respack %0b respcyc %0b expected 0 00", a_bus_respack, a_respcyc); end
        a_bus_respcyc = 1'b0;
    endtask

    task automatic test_write_stall();
        int acks = 0;
        int saw_resp = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); #1;
            if (dut2.state == RESP) saw_resp++;
            checks++; if (dut2.state !== ADDR || a_grant !== 1'b1 || a_bus_reqtag !== 13'h1040 || a_bus_req !== ADDR1) begin
                errors++; $display("FAIL write_addr%0d: state %0d grant %0d tag %0h expected %0d 1 1040", s, dut2.state, a_grant, a_bus_reqtag, ADDR); end
            checks++; if (a_reqack !== 2'b00) begin errors++; $display("FAIL stall_ack%0d: got %0b expected 00", s, a_reqack); end
        end
        @(negedge clk);
        a_bus_reqack = 1'b1;
        #1;
        if (a_reqack == 2'b10) acks++;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            a_req[127:64] = 64'hBEEF_0000 + 64'(b);
            a_bus_respcyc = (b == 2);
            #1;
            if (dut2.state == RESP) saw_resp++;
            if (a_reqack == 2'b10) acks++;
            checks++; if (dut2.state !== WDATA || a_bus_req !== 64'hBEEF_0000 + 64'(b) || a_reqack !== 2'b10) begin
                errors++; $display("FAIL wdata%0d: state %0d req %0h ack %0b expected %0d %0h 10", b, dut2.state, a_bus_req, a_reqack, WDATA, 64'hBEEF_0000 + 64'(b)); end
            if (b == 2) begin
                checks++; if (a_bus_respack !== 1'b0 || a_respcyc !== 2'b00) begin
                    errors++; $display("FAIL wdata_drop_resp: respack %0b respcyc %0b expected 0 00", a_bus_respack, a_respcyc); end
            end
        end
        @(negedge clk);
        a_reqcyc      = 2'b00;
        a_bus_reqack  = 1'b0;
        a_bus_respcyc = 1'b0;
        #1;
        checks++; if (acks != 9) begin errors++; $display("FAIL write_acks: got %0d expected 9", acks); end
        checks++; if (dut2.state !== IDLE || dut2.rr_ptr !== 1'b0 || saw_resp != 0) begin
            errors++; $display("FAIL write_done: state %0d rr_ptr %0d resp_cycles %0d expected %0d 0 0", dut2.state, dut2.rr_ptr, saw_resp, IDLE); end
        @(negedge clk); #1;
        checks++; if (dut2.state !== IDLE) begin errors++; $display("FAIL write_stays_idle: got %0d expected %0d", dut2.state, IDLE); end
    endtask

    task automatic test_abandon();
        @(negedge clk);
        a_reqcyc = 2'b01;
        a_reqtag = {13'h1040, 13'h0040};
        @(negedge clk);
        a_reqcyc = 2'b00;
        #1;
        checks++; if (dut2.state !== ADDR || a_bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL abandon_addr: state %0d bus_reqcyc %0b expected %0d 0", dut2.state, a_bus_reqcyc, ADDR); end
        @(negedge clk); #1;
        checks++; if (dut2.state !== IDLE || dut2.rr_ptr !== 1'b0) begin
            errors++; $display("FAIL abandon_idle: state %0d rr_ptr %0d expected %0d 0", dut2.state, dut2.rr_ptr, IDLE); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_reqcyc = 2'b10;
        a_reqtag = {13'h0041, 13'h0000};
        @(negedge clk);
        a_bus_reqack = 1'b1;
        #1;
        checks++; if (a_grant !== 1'b1 || a_reqack !== 2'b10) begin errors++; $display("FAIL mid_grant: grant %0d ack %0b expected 1 10", a_grant, a_reqack); end
        @(negedge clk);
        a_bus_reqack = 1'b0;
        a_reqcyc     = 2'b00;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            a_bus_respcyc = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (a_respcyc !== 2'b10 || dut2.beat_cnt !== 4'd4) begin
            errors++; $display("FAIL beat5_presented: respcyc %0b cnt %0d expected 10 4", a_respcyc, dut2.beat_cnt); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (dut2.state !== IDLE || a_grant !== 1'b0 || dut2.beat_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_reset_state: state %0d grant %0d cnt %0d expected %0d 0 0", dut2.state, a_grant, dut2.beat_cnt, IDLE); end
        checks++; if ({a_bus_reqcyc, a_bus_req, a_bus_reqtag, a_reqack, a_respcyc, a_resp, a_resptag, a_bus_respack} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: respcyc %0b bus_respack %0b expected all 0", a_respcyc, a_bus_respack); end
        @(negedge clk);
        a_bus_respcyc = 1'b0;
    endtask

    task automatic test_rr4();
        logic [1:0] exp_g [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [1:0] got_g [$];
        logic [3:0] stray = '0;
        @(negedge clk);
        b_reqcyc      = 4'b1010;
        b_reqtag      = '0;
        b_bus_reqack  = 1'b1;
        b_bus_respcyc = 1'b1;
        b_respack     = 4'hF;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (dut4.state == ADDR) got_g.push_back(b_grant);
            stray |= (b_reqack | b_respcyc) & 4'b0101;
        end
        b_reqcyc = 4'b0000;
        checks++; if (got_g.size() != 4) begin errors++; $display("FAIL rr4_count: got %0d expected 4", got_g.size()); end
        for (int i = 0; i < 4 && i < got_g.size(); i++) begin
            checks++; if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL rr4_grant%0d: got %0d expected %0d", i, got_g[i], exp_g[i]); end
        end
        checks++; if (stray !== 4'b0000) begin errors++; $display("FAIL rr4_stray: got %0b expected 0000", stray); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        // NOTE: bench inputs are driven with blocking assignments from this single process.
        reset = 1'b1;
        a_reqcyc = '0; a_req = '0; a_reqtag = '0; a_respack = '0;
        a_bus_reqack = 1'b0; a_bus_respcyc = 1'b0; a_bus_resp = '0; a_bus_resptag = '0;
        b_reqcyc = '0; b_req = '0; b_reqtag = '0; b_respack = '0;
        b_bus_reqack = 1'b0; b_bus_respcyc = 1'b0; b_bus_resp = '0; b_bus_resptag = '0;
        test_reset();
        test_arb_read();
        test_write_stall();
        test_abandon();
        test_reset_mid();
        test_rr4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule
